fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
Time-multiplexed scheduler that shares one MAC datapath (coefficient ROM, per-channel circular sample RAM, 48-bit accumulator) between NCH microphone channels of the decimation chain. It arbitrates incoming channel samples round-robin and writes each accepted sample into that channel's circular buffer. It then sequences NTAPS multiply-accumulate cycles, waits for the MAC pipeline to flush, and presents the filtered result with a valid/ready handshake. This replaces one fully parallel MAC chain per channel with a single shared engine.

Parameters:
NCH, 4, number of requesting channels (power of 2, >=2)
NTAPS, 35, filter length; must satisfy NTAPS <= 2^AW
AW, 6, per-channel sample buffer address width (buffer depth 2^AW)
MAC_LAT, 2, pipeline latency from mac_en to accumulator result; range 1..7
CHW, clog2(NCH), channel index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  NCH  per-channel sample available
in_ready  out  NCH  one-hot accept pulse to the granted channel
samp_we  out  1  sample RAM write enable
samp_waddr  out  CHW+AW  sample RAM write address {ch, wr_ptr[ch]}
tap_addr  out  CHW+AW  sample RAM read address
coeff_addr  out  AW  coefficient ROM address
mac_clr  out  1  load accumulator with product instead of adding (first tap)
mac_en  out  1  MAC operand valid
mac_last  out  1  final tap of the current sum
out_valid  out  1  accumulator result valid
out_ch  out  CHW  channel of the presented result
out_ready  in  1  downstream accepts the result
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered except in_ready, samp_we and samp_waddr, which are combinational from state, in_valid and rr_ptr.
- Reset, including reset asserted mid-operation:
  - state=IDLE; all outputs 0; wr_ptr[0..NCH-1]=0; rr_ptr=0, which gives ch0 first priority; any sum in progress is discarded.
- FSM: IDLE -> RUN -> WAIT -> OUT -> IDLE.
- IDLE:
  - If any in_valid bit is high, grant g = first requesting channel searching upward from rr_ptr, with wrap-around.
  - In the same cycle: in_ready[g]=1, samp_we=1, samp_waddr={g, wr_ptr[g]}.
  - At the clock edge: latch g, set rr_ptr=g+1 mod NCH, k=0, go to RUN.
  - With no request: stay in IDLE; in_ready=0 and samp_we=0.
- RUN, exactly NTAPS cycles:
  - Each cycle: mac_en=1, coeff_addr=k, tap_addr={g, (wr_ptr[g]-k) mod 2^AW}.
  - mac_clr=1 only when k=0; mac_last=1 only when k=NTAPS-1.
  - At k=NTAPS-1: wr_ptr[g] increments (wraps at 2^AW); go to WAIT with a wait counter of 0.
- WAIT, exactly MAC_LAT cycles, all mac_* outputs 0; then go to OUT.
- OUT:
  - out_valid=1, out_ch=g. Both are held stable until out_ready=1 is sampled.
  - On out_ready: go to IDLE, with out_valid falling in the following cycle.
  - Back-pressure stalls the scheduler; no new samples are accepted while in OUT.
- Latency: with in_valid accepted at edge T, RUN covers T+1..T+NTAPS, and out_valid first rises at T+NTAPS+MAC_LAT+1.
  - Default parameters: 38 cycles; minimum period 39 cycles per sample.
- Boundary rules:
  - in_valid deasserted while another channel is mid-sum is ignored; the channel is simply not granted.
  - A channel requesting continuously cannot starve the others, because rr_ptr rotates after every grant.
  - Tap read addresses wrap modulo 2^AW within the channel's own region; taps never read another channel's region.
  - Samples older than NTAPS-1 are overwritten without error.
- Assertion: a one-hot check on in_ready.

Optional Feature:
SYM_FOLD_EN: symmetric-coefficient folding.
- Defined:
  - Extra output tap_addr_b (CHW+AW) = {g, (wr_ptr[g]-(NTAPS-1-k)) mod 2^AW}.
  - Extra output mac_mid (1) is high on the centre tap (k=(NTAPS-1)/2, NTAPS odd); the datapath then adds only one operand.
  - RUN lasts NF=(NTAPS+1)/2 cycles; mac_last is asserted at k=NF-1; latency becomes NF+MAC_LAT+1 (21 cycles by default).
- Undefined: tap_addr_b and mac_mid do not exist, and the behaviour is exactly as above.

Test Plan:
- Reset then single request in_valid=4'b0001 at edge T -> in_ready=0001 at T; mac_en high on exactly 35 consecutive cycles with coeff_addr 0..34 and tap_addr 0,63,62,...,30; mac_clr only with coeff_addr 0; out_valid at T+38 with out_ch=0; wr_ptr[0]=1 afterwards.
- All four in_valid held high with out_ready=1 -> grant order 0,1,2,3,0,...; in_ready pulses exactly 39 cycles apart.
- out_ready held low for 10 cycles in OUT -> out_valid and out_ch remain stable; in_ready stays 0 despite pending requests; IDLE is re-entered the cycle after out_ready rises.
- 64 samples on ch2 -> wr_ptr[2] wraps 63->0; the next sum's tap_addr sequence wraps 0,63,... within base address 2<<6=128.
- rst asserted in RUN at k=17 -> all outputs 0 immediately; wr_ptr[ch] unchanged from 0; the next request on ch1 is granted ahead of ch0 only if ch0 is not requesting.
- With SYM_FOLD_EN defined -> 18 mac_en cycles; tap_addr/tap_addr_b pairs (0,30),(63,31),...; mac_mid at k=17; out_valid at T+21.

Source files
------------

// File: rtl/fir_mac_sched.sv
// Shared-MAC scheduler: round-robin sample intake, NTAPS-cycle MAC sequencing, flush, valid/ready result.
// Optional symmetric-coefficient folding is enabled by defining SYM_FOLD_EN.
module fir_mac_sched #(
   parameter int NCH     = 4,
   parameter int NTAPS   = 35,
   parameter int AW      = 6,
   parameter int MAC_LAT = 2,
   localparam int CHW    = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      in_valid,
   output logic [NCH-1:0]      in_ready,
   output logic                samp_we,
   output logic [CHW+AW-1:0]   samp_waddr,
   output logic [CHW+AW-1:0]   tap_addr,
`ifdef SYM_FOLD_EN
   output logic [CHW+AW-1:0]   tap_addr_b,
   output logic                mac_mid,
`endif
   output logic [AW-1:0]       coeff_addr,
   output logic                mac_clr,
   output logic                mac_en,
   output logic                mac_last,
   output logic                out_valid,
   output logic [CHW-1:0]      out_ch,
   input  logic                out_ready,
   output logic                busy
);

   // state  | meaning
   // S_IDLE | waiting for any channel request; grants combinationally
   // S_RUN  | issuing one MAC operand pair per cycle, k = tap index
   // S_WAIT | MAC pipeline flush, MAC_LAT cycles
   // S_OUT  | result presented, held until out_ready
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_OUT} state_t;

`ifdef SYM_FOLD_EN
   localparam int NRUN = (NTAPS + 1) / 2;
`else
   localparam int NRUN = NTAPS;
`endif
   localparam logic [AW-1:0] K_LAST = AW'(NRUN - 1);
   localparam logic [2:0]    W_LAST = 3'(MAC_LAT - 1);

   state_t             state_q, state_d;
   logic [CHW-1:0]     g_q, g_d;
   logic [CHW-1:0]     rr_q, rr_d;
   logic [AW-1:0]      k_q, k_d;
   logic [2:0]         w_q, w_d;
   logic [AW-1:0]      wr_ptr_q [NCH];
   logic [AW-1:0]      wr_ptr_d [NCH];

   logic [CHW+AW-1:0]  tap_addr_q, tap_addr_d;
   logic [AW-1:0]      coeff_addr_q, coeff_addr_d;
   logic               mac_clr_q, mac_clr_d;
   logic               mac_en_q, mac_en_d;
   logic               mac_last_q, mac_last_d;
   logic               out_valid_q, out_valid_d;
   logic [CHW-1:0]     out_ch_q, out_ch_d;
   logic               busy_q, busy_d;
`ifdef SYM_FOLD_EN
   localparam bit            HAS_MID = (NTAPS % 2) == 1;
   localparam logic [AW-1:0] K_MID   = AW'((NTAPS - 1) / 2);
   localparam logic [AW-1:0] K_TOP   = AW'(NTAPS - 1);
   logic [CHW+AW-1:0]  tap_addr_b_q, tap_addr_b_d;
   logic               mac_mid_q, mac_mid_d;
`endif

   logic               gnt_found;
   logic [CHW-1:0]     gnt_idx;
   logic [CHW-1:0]     cand;
   logic               accept;
   logic               run_d;

   // First requester at or above rr_q, wrapping within the channel index width.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = rr_q + CHW'(i);
         if (!gnt_found && in_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign accept     = (state_q == S_IDLE) && gnt_found && !rst;
   assign in_ready   = accept ? (NCH'(1) << gnt_idx) : '0;
   assign samp_we    = accept;
   assign samp_waddr = accept ? {gnt_idx, wr_ptr_q[gnt_idx]} : '0;

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      rr_d     = rr_q;
      k_d      = k_q;
      w_d      = w_q;
      wr_ptr_d = wr_ptr_q;
      case (state_q)
         S_IDLE: if (accept) begin
            g_d     = gnt_idx;
            rr_d    = gnt_idx + 1'b1;
            k_d     = '0;
            state_d = S_RUN;
         end
         S_RUN: if (k_q == K_LAST) begin
            wr_ptr_d[g_q] = wr_ptr_q[g_q] + 1'b1;
            w_d           = '0;
            state_d       = S_WAIT;
         end else begin
            k_d = k_q + 1'b1;
         end
         S_WAIT: if (w_q == W_LAST) state_d = S_OUT;
                 else               w_d     = w_q + 1'b1;
         S_OUT:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      // wr_ptr_q is still the pre-increment pointer for every RUN cycle.
      run_d        = (state_d == S_RUN);
      mac_en_d     = run_d;
      mac_clr_d    = run_d && (k_d == '0);
      mac_last_d   = run_d && (k_d == K_LAST);
      coeff_addr_d = run_d ? k_d : '0;
      tap_addr_d   = run_d ? {g_d, wr_ptr_q[g_d] - k_d} : '0;
`ifdef SYM_FOLD_EN
      tap_addr_b_d = run_d ? {g_d, wr_ptr_q[g_d] - (K_TOP - k_d)} : '0;
      mac_mid_d    = run_d && HAS_MID && (k_d == K_MID);
`endif
      out_valid_d  = (state_d == S_OUT);
      out_ch_d     = (state_d == S_OUT) ? g_d : '0;
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         g_q          <= '0;
         rr_q         <= '0;
         k_q          <= '0;
         w_q          <= '0;
         for (int i = 0; i < NCH; i++) wr_ptr_q[i] <= '0;
         tap_addr_q   <= '0;
         coeff_addr_q <= '0;
         mac_clr_q    <= 1'b0;
         mac_en_q     <= 1'b0;
         mac_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         busy_q       <= 1'b0;
`ifdef SYM_FOLD_EN
         tap_addr_b_q <= '0;
         mac_mid_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         rr_q         <= rr_d;
         k_q          <= k_d;
         w_q          <= w_d;
         wr_ptr_q     <= wr_ptr_d;
         tap_addr_q   <= tap_addr_d;
         coeff_addr_q <= coeff_addr_d;
         mac_clr_q    <= mac_clr_d;
         mac_en_q     <= mac_en_d;
         mac_last_q   <= mac_last_d;
         out_valid_q  <= out_valid_d;
         out_ch_q     <= out_ch_d;
         busy_q       <= busy_d;
`ifdef SYM_FOLD_EN
         tap_addr_b_q <= tap_addr_b_d;
         mac_mid_q    <= mac_mid_d;
`endif
      end
   end

   assign tap_addr   = tap_addr_q;
   assign coeff_addr = coeff_addr_q;
   assign mac_clr    = mac_clr_q;
   assign mac_en     = mac_en_q;
   assign mac_last   = mac_last_q;
   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign busy       = busy_q;
`ifdef SYM_FOLD_EN
   assign tap_addr_b = tap_addr_b_q;
   assign mac_mid    = mac_mid_q;
`endif

   a_in_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed/random bench for fir_mac_sched against a queue-free arithmetic reference model.
module tb_fir_mac_sched;
   localparam int NCH = 4, NTAPS = 35, AW = 6, MAC_LAT = 2, CHW = 2, DEPTH = 64;
`ifdef SYM_FOLD_EN
   localparam int NR = (NTAPS + 1) / 2;
`else
   localparam int NR = NTAPS;
`endif

   logic              clk, rst, samp_we, mac_clr, mac_en, mac_last, out_valid, out_ready, busy;
   logic [NCH-1:0]    in_valid, in_ready;
   logic [CHW+AW-1:0] samp_waddr, tap_addr;
   logic [AW-1:0]     coeff_addr;
   logic [CHW-1:0]    out_ch;
`ifdef SYM_FOLD_EN
   logic [CHW+AW-1:0] tap_addr_b;
   logic              mac_mid;
`endif

   fir_mac_sched #(.NCH(NCH), .NTAPS(NTAPS), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .samp_we(samp_we), .samp_waddr(samp_waddr), .tap_addr(tap_addr),
`ifdef SYM_FOLD_EN
      .tap_addr_b(tap_addr_b), .mac_mid(mac_mid),
`endif
      .coeff_addr(coeff_addr), .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
      .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   int wp_m [NCH];
   int rr_m = 0;
   int last_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % DEPTH) + DEPTH) % DEPTH;
   endfunction

   function automatic int pick(input logic [NCH-1:0] req);
      for (int i = 0; i < NCH; i++)
         if (req[(rr_m + i) % NCH]) return (rr_m + i) % NCH;
      return -1;
   endfunction

   // One full transaction starting at a negedge with the DUT idle; returns at a negedge, idle again.
   task automatic txn(input logic [NCH-1:0] req, input int stall, input bit chk_period);
      int g;
      g = pick(req);
      in_valid = req;
      #1;
      chk("in_ready", in_ready, 32'(1 << g));
      chk("samp_we", samp_we, 1);
      chk("samp_waddr", samp_waddr, g * DEPTH + wp_m[g]);
      if (chk_period) chk("period", cyc - last_acc, NR + MAC_LAT + 2);
      last_acc = cyc;
      rr_m = (g + 1) % NCH;
      for (int k = 0; k < NR; k++) begin
         @(negedge clk);
         chk("mac_en", mac_en, 1);
         chk("coeff_addr", coeff_addr, k);
         chk("tap_addr", tap_addr, g * DEPTH + wrap(wp_m[g] - k));
         chk("mac_clr", mac_clr, (k == 0));
         chk("mac_last", mac_last, (k == NR - 1));
         chk("busy_run", busy, 1);
`ifdef SYM_FOLD_EN
         chk("tap_addr_b", tap_addr_b, g * DEPTH + wrap(wp_m[g] - (NTAPS - 1 - k)));
         chk("mac_mid", mac_mid, (NTAPS % 2 == 1) && (k == (NTAPS - 1) / 2));
`endif
         in_valid = NCH'($urandom);
         #1;
         chk("in_ready_run", in_ready, 0);
      end
      wp_m[g] = (wp_m[g] + 1) % DEPTH;
      for (int w = 0; w < MAC_LAT; w++) begin
         @(negedge clk);
         chk("mac_en_wait", mac_en, 0);
         chk("out_valid_wait", out_valid, 0);
      end
      @(negedge clk);
      chk("latency", cyc - last_acc, NR + MAC_LAT + 1);
      chk("out_valid", out_valid, 1);
      chk("out_ch", out_ch, g);
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         in_valid  = NCH'($urandom);
         #1;
         chk("in_ready_out", in_ready, 0);
         @(negedge clk);
         chk("out_valid_hold", out_valid, 1);
         chk("out_ch_hold", out_ch, g);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = '0;
      chk("out_valid_drop", out_valid, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; out_ready = 1'b0;
      for (int i = 0; i < NCH; i++) wp_m[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_req", in_ready, 0);
      chk("idle_no_we", samp_we, 0);

      txn(4'b0001, 0, 1'b0);
      for (int n = 0; n < 8; n++) txn(4'b1111, 0, n > 0);
      txn(4'b1111, 10, 1'b1);
      txn(4'b1111, 0, 1'b0);
      for (int n = 0; n < 65; n++) txn(4'b0100, 0, n > 0);
      for (int n = 0; n < 12; n++) txn(NCH'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);

      // Reset in the middle of a sum on ch1.
      in_valid = 4'b0010;
      @(negedge clk);
      in_valid = '0;
      for (int n = 0; n < 60 && coeff_addr != 17; n++) @(negedge clk);
      chk("reached_k17", coeff_addr, 17);
      in_valid = 4'b0011;
      rst = 1'b1;
      #1;
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_samp_we", samp_we, 0);
      chk("mrst_mac_en", mac_en, 0);
      chk("mrst_tap_addr", tap_addr, 0);
      chk("mrst_coeff", coeff_addr, 0);
      chk("mrst_clr_last", {mac_clr, mac_last}, 0);
      chk("mrst_out", {out_valid, out_ch}, 0);
      chk("mrst_busy", busy, 0);
      for (int i = 0; i < NCH; i++) wp_m[i] = 0;
      rr_m = 0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = '0;
      @(negedge clk);
      txn(4'b0011, 0, 1'b0);
      txn(4'b0010, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
